burst_sequencer: RTL and testbench

//  Sequences the waveform engine for burst and continuous output modes.
//  - On a trigger, loads the 20-bit burst count register.
//  - Gates the waveform engine for exactly N waveform periods, then signals completion.
//  - Sits between front-panel/host control and the waveform address/phase datapath.

---
 rtl/burst_sequencer.sv | 158 +++++++++++++++
 tb/tb_burst_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_sequencer.sv
// -----------------------------------------------------------------------------
// burst_sequencer
//   Gates the waveform engine for either continuous output or a triggered burst
//   of exactly N waveform periods. It sits between front-panel/host control and
//   the waveform address/phase datapath.
//
// Ports
//   Clock      in   1   system clock, rising edge
//   Reset      in   1   synchronous, active-high
//   Enable     in   1   master output enable, low forces IDLE
//   Mode       in   1   0 = continuous, 1 = triggered burst
//   Trig       in   1   synchronous trigger level (rising edge detected here)
//   Count_In   in   CW  requested burst length in waveform periods
//   Cycle_End  in   1   end-of-period pulse from the waveform engine
//   Abort      in   1   immediate stop request
//   Wave_EN    out  1   gate to waveform engine
//   Count_LD   out  1   load strobe to burst count register
//   Busy       out  1   high while in LOAD, BURST or CONT
//   Done       out  1   one-cycle pulse on normal burst completion
//   Remaining  out  CW  periods left in the current burst
// -----------------------------------------------------------------------------
module burst_sequencer #(
  parameter int CW               = 20,
  parameter bit INFINITE_ON_ZERO = 1'b1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Enable,
  input  logic          Mode,
  input  logic          Trig,
  input  logic [CW-1:0] Count_In,
  input  logic          Cycle_End,
  input  logic          Abort,
  output logic          Wave_EN,
  output logic          Count_LD,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] Remaining
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    BURST = 3'd2,
    CONT  = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = '0;

  state_t        state;
  state_t        state_nxt;
  logic          trig_d;
  logic          trig_armed;
  logic          trig_edge;
  logic [CW-1:0] remaining_nxt;
  logic          wave_en_nxt;
  logic          count_ld_nxt;
  logic          busy_nxt;
  logic          done_nxt;

  // A trigger held high through reset must not start a burst when reset is
  // released: the level has to be seen low first (trig_armed) before a rising
  // edge counts.
  always_comb begin
    trig_edge = Trig & ~trig_d & trig_armed;
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = Remaining;
    case (state)
      IDLE: begin
        if (Enable) begin
          if (!Mode) begin
            state_nxt = CONT;
          end else if (trig_edge) begin
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (!Enable || Abort) begin
          state_nxt = IDLE;
        end else begin
          remaining_nxt = Count_In;
          if (Count_In != ZERO) begin
            state_nxt = BURST;
          end else if (INFINITE_ON_ZERO) begin
            state_nxt = CONT;
          end else begin
            state_nxt = FIN;
          end
        end
      end
      BURST: begin
        if (!Enable || Abort) begin
          state_nxt = IDLE;
        end else if (Cycle_End) begin
          // Only decrement from >=1 so the counter can never wrap.
          if (Remaining > ONE) begin
            remaining_nxt = Remaining - ONE;
          end else if (Remaining == ONE) begin
            remaining_nxt = ZERO;
            state_nxt     = FIN;
          end
        end
      end
      CONT: begin
        // Mode changes are deliberately ignored here; they apply after IDLE.
        if (!Enable || Abort) begin
          state_nxt = IDLE;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so every output flop changes on
  // the same edge as the state it describes. Wave_EN additionally stays low on
  // the edge leaving LOAD, giving the count register one settled cycle before
  // the datapath runs.
  always_comb begin
    wave_en_nxt  = ((state_nxt == BURST) || (state_nxt == CONT)) && (state != LOAD);
    count_ld_nxt = (state_nxt == LOAD);
    busy_nxt     = (state_nxt == LOAD) || (state_nxt == BURST) || (state_nxt == CONT);
    done_nxt     = (state_nxt == FIN);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      trig_d     <= 1'b0;
      trig_armed <= 1'b0;
      Wave_EN    <= 1'b0;
      Count_LD   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Remaining  <= ZERO;
    end else begin
      state      <= state_nxt;
      trig_d     <= Trig;
      trig_armed <= trig_armed | ~Trig;
      Wave_EN    <= wave_en_nxt;
      Count_LD   <= count_ld_nxt;
      Busy       <= busy_nxt;
      Done       <= done_nxt;
      Remaining  <= remaining_nxt;
    end
  end

endmodule

// File: tb/tb_burst_sequencer.sv
module tb_burst_sequencer;

  localparam int CW = 20;

  logic          Clock;
  logic          Reset;
  logic          Enable;
  logic          Mode;
  logic          Trig;
  logic [CW-1:0] Count_In;
  logic          Cycle_End;
  logic          Abort;
  logic          Wave_EN;
  logic          Count_LD;
  logic          Busy;
  logic          Done;
  logic [CW-1:0] Remaining;

  int pass_cnt;
  int total_cnt;

  burst_sequencer #(.CW(CW), .INFINITE_ON_ZERO(1'b1)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Enable    (Enable),
    .Mode      (Mode),
    .Trig      (Trig),
    .Count_In  (Count_In),
    .Cycle_End (Cycle_End),
    .Abort     (Abort),
    .Wave_EN   (Wave_EN),
    .Count_LD  (Count_LD),
    .Busy      (Busy),
    .Done      (Done),
    .Remaining (Remaining)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one rising edge, then settle 1 ns so outputs of that edge are visible.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Enable = 1'b0; Mode = 1'b0; Trig = 1'b0;
    Count_In = '0; Cycle_End = 1'b0; Abort = 1'b0;
    step(); step();
    total_cnt++;
    if ({Wave_EN, Count_LD, Busy, Done} !== 4'b0000)
      $display("FAIL reset_flags got=%b want=0000", {Wave_EN, Count_LD, Busy, Done});
    else pass_cnt++;
    total_cnt++;
    if (Remaining !== 20'h0) $display("FAIL reset_remaining got=%h want=00000", Remaining);
    else pass_cnt++;
    Reset = 1'b0;
    step();
  endtask

  task automatic test_burst3();
    logic [CW-1:0] exp_rem;
    Enable = 1'b1; Mode = 1'b1; Count_In = 20'd3; Trig = 1'b0;
    step();
    Trig = 1'b1;
    step();
    total_cnt++;
    if ({Count_LD, Wave_EN, Busy} !== 3'b101)
      $display("FAIL b3_load got=%b want=101", {Count_LD, Wave_EN, Busy});
    else pass_cnt++;
    Trig = 1'b0;
    step();
    total_cnt++;
    if ({Count_LD, Wave_EN, Remaining} !== {2'b00, 20'd3})
      $display("FAIL b3_loaded ld/wen=%b rem=%0d want 00/3", {Count_LD, Wave_EN}, Remaining);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({Wave_EN, Busy} !== 2'b11) $display("FAIL b3_wave_on got=%b want=11", {Wave_EN, Busy});
    else pass_cnt++;
    for (int p = 1; p <= 3; p++) begin
      repeat (7) step();
      Cycle_End = 1'b1;
      step();
      Cycle_End = 1'b0;
      exp_rem = 20'd3 - CW'(p);
      total_cnt++;
      if (Remaining !== exp_rem) $display("FAIL b3_rem%0d got=%0d want=%0d", p, Remaining, exp_rem);
      else pass_cnt++;
      total_cnt++;
      if (p == 3) begin
        if ({Wave_EN, Done, Busy} !== 3'b010)
          $display("FAIL b3_finish wen/done/busy got=%b want=010", {Wave_EN, Done, Busy});
        else pass_cnt++;
      end else begin
        if (Wave_EN !== 1'b1) $display("FAIL b3_wave_mid%0d got=%b want=1", p, Wave_EN);
        else pass_cnt++;
      end
    end
    step();
    total_cnt++;
    if ({Done, Busy, Wave_EN, Remaining} !== {3'b000, 20'd0})
      $display("FAIL b3_after done/busy/wen=%b rem=%0d want 000/0", {Done, Busy, Wave_EN}, Remaining);
    else pass_cnt++;
  endtask

  task automatic test_infinite();
    logic bad;
    Count_In = 20'd0; Trig = 1'b1;
    step();
    Trig = 1'b0;
    step();
    step();
    total_cnt++;
    if ({Wave_EN, Busy, Remaining} !== {2'b11, 20'd0})
      $display("FAIL inf_cont wen/busy=%b rem=%0d want 11/0", {Wave_EN, Busy}, Remaining);
    else pass_cnt++;
    bad = 1'b0;
    Cycle_End = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (Wave_EN !== 1'b1 || Done !== 1'b0 || Remaining !== 20'd0) bad = 1'b1;
    end
    Cycle_End = 1'b0;
    total_cnt++;
    if (bad !== 1'b0) $display("FAIL inf_hold got=%b want=0", bad);
    else pass_cnt++;
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    total_cnt++;
    if ({Wave_EN, Busy, Done} !== 3'b000)
      $display("FAIL inf_abort wen/busy/done got=%b want=000", {Wave_EN, Busy, Done});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({Wave_EN, Done, Count_LD} !== 3'b000)
      $display("FAIL inf_idle wen/done/ld got=%b want=000", {Wave_EN, Done, Count_LD});
    else pass_cnt++;
  endtask

  task automatic test_retrig_abort();
    Count_In = 20'd5; Trig = 1'b1;
    step();
    Trig = 1'b0;
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      Cycle_End = 1'b1; step();
      Cycle_End = 1'b0; step();
    end
    Trig = 1'b1;
    step();
    total_cnt++;
    if ({Count_LD, Wave_EN, Remaining} !== {2'b01, 20'd3})
      $display("FAIL rt_retrig ld/wen=%b rem=%0d want 01/3", {Count_LD, Wave_EN}, Remaining);
    else pass_cnt++;
    Trig = 1'b0;
    step();
    Cycle_End = 1'b1; Abort = 1'b1;
    step();
    Cycle_End = 1'b0; Abort = 1'b0;
    total_cnt++;
    if ({Wave_EN, Busy, Done, Remaining} !== {3'b000, 20'd3})
      $display("FAIL rt_abort wen/busy/done=%b rem=%0d want 000/3", {Wave_EN, Busy, Done}, Remaining);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({Count_LD, Busy, Remaining} !== {2'b00, 20'd3})
      $display("FAIL rt_idle ld/busy=%b rem=%0d want 00/3", {Count_LD, Busy}, Remaining);
    else pass_cnt++;
  endtask

  task automatic test_max_count();
    logic [CW-1:0] exp_rem;
    Count_In = 20'hFFFFF; Trig = 1'b1;
    step();
    Trig = 1'b0;
    step();
    step();
    Cycle_End = 1'b1;
    exp_rem = 20'hFFFFF;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_rem = exp_rem - 20'd1;
      total_cnt++;
      if (Remaining !== exp_rem) $display("FAIL max_rem%0d got=%h want=%h", i, Remaining, exp_rem);
      else pass_cnt++;
    end
    Cycle_End = 1'b0;
    Enable = 1'b0;
    step();
    total_cnt++;
    if ({Wave_EN, Busy, Remaining} !== {2'b00, 20'hFFFFB})
      $display("FAIL max_disable wen/busy=%b rem=%h want 00/FFFFB", {Wave_EN, Busy}, Remaining);
    else pass_cnt++;
  endtask

  task automatic test_continuous();
    logic stray;
    stray = 1'b0;
    Mode = 1'b0; Enable = 1'b1;
    step();
    if (Count_LD !== 1'b0 || Done !== 1'b0) stray = 1'b1;
    total_cnt++;
    if ({Wave_EN, Busy} !== 2'b11) $display("FAIL cont_on got=%b want=11", {Wave_EN, Busy});
    else pass_cnt++;
    Enable = 1'b0;
    step();
    if (Count_LD !== 1'b0 || Done !== 1'b0) stray = 1'b1;
    total_cnt++;
    if ({Wave_EN, Busy} !== 2'b00) $display("FAIL cont_off got=%b want=00", {Wave_EN, Busy});
    else pass_cnt++;
    Enable = 1'b1;
    step();
    if (Count_LD !== 1'b0 || Done !== 1'b0) stray = 1'b1;
    total_cnt++;
    if ({Wave_EN, Busy} !== 2'b11) $display("FAIL cont_reon got=%b want=11", {Wave_EN, Busy});
    else pass_cnt++;
    Cycle_End = 1'b1;
    step();
    Cycle_End = 1'b0;
    if (Count_LD !== 1'b0 || Done !== 1'b0) stray = 1'b1;
    total_cnt++;
    if (stray !== 1'b0) $display("FAIL cont_stray_strobe got=%b want=0", stray);
    else pass_cnt++;
    Enable = 1'b0;
    step();
    Mode = 1'b1; Enable = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_burst();
    logic early;
    Count_In = 20'd10; Trig = 1'b0;
    step();
    Trig = 1'b1;
    step();
    step();
    step();
    total_cnt++;
    if ({Wave_EN, Remaining} !== {1'b1, 20'd10})
      $display("FAIL rst_pre wen=%b rem=%0d want 1/10", Wave_EN, Remaining);
    else pass_cnt++;
    Reset = 1'b1;
    step(); step();
    total_cnt++;
    if ({Wave_EN, Count_LD, Busy, Done, Remaining} !== {4'b0000, 20'd0})
      $display("FAIL rst_mid flags=%b rem=%0d want 0000/0", {Wave_EN, Count_LD, Busy, Done}, Remaining);
    else pass_cnt++;
    Reset = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (Count_LD !== 1'b0 || Busy !== 1'b0) early = 1'b1;
    end
    total_cnt++;
    if (early !== 1'b0) $display("FAIL rst_no_load got=%b want=0", early);
    else pass_cnt++;
    Trig = 1'b0;
    step();
    Trig = 1'b1;
    step();
    total_cnt++;
    if (Count_LD !== 1'b1) $display("FAIL rst_reload got=%b want=1", Count_LD);
    else pass_cnt++;
    step();
    total_cnt++;
    if (Remaining !== 20'd10) $display("FAIL rst_reload_rem got=%0d want=10", Remaining);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_burst3();
    test_infinite();
    test_retrig_abort();
    test_max_count();
    test_continuous();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
